// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA request arbiter.
//   - NchDefault / BeatsDefault : default channel count and beats per transfer
//   - arb_state_e               : arbiter FSM state encoding
//   - wrap_idx()                : modulo helper for round-robin index arithmetic
package dma_arb_pkg;

  localparam int unsigned NchDefault   = 4;
  localparam int unsigned BeatsDefault = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StXfer  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  // Reduce an index into the range 0..n-1.
  function automatic int unsigned wrap_idx(input int unsigned idx, input int unsigned n);
    return idx % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set bit of req at or above ptr, searching upward
// and wrapping from NCH-1 back to 0.
// Ports:
//   req   - request vector, one bit per channel
//   ptr   - channel index where the search starts
//   grant - index of the winning channel (0 when nothing is requested)
//   valid - high when any request bit is set
module rr_pick
  import dma_arb_pkg::*;
#(
  parameter int unsigned NCH = NchDefault
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] grant,
  output logic                   valid
);

  localparam int unsigned ChW = $clog2(NCH);

  logic [ChW-1:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      cand = ChW'(wrap_idx(32'(ptr) + off, NCH));
      // First hit wins; later candidates are further from ptr.
      if (!valid && req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_req_arb.sv
// DMA request arbiter: shares one AHB master port among NCH channels, each with a level
// read request and a level write request. A round-robin pointer picks the next channel;
// a channel asking for both directions gets its write first. Each grant issues one
// mst_start and then counts BEATS data beats (or stops early on mst_err) before pulsing
// req_done (and req_err on error) back to the granted channel.
// Ports:
//   hclk, hresetn      - clock and asynchronous active-low reset
//   rd_req, wr_req     - per-channel level requests, held until req_done
//   req_done, req_err  - one-cycle completion / error pulse on the granted channel
//   mst_start          - transfer start to the master, only in GRANT and only while ready
//   mst_write, mst_ch  - direction and channel of the current/last grant
//   mst_ready          - master can accept mst_start
//   mst_beat, mst_err  - beat completion and error response from the master
//   busy               - arbiter is not idle
module dma_req_arb
  import dma_arb_pkg::*;
#(
  parameter int unsigned NCH   = NchDefault,   // 2..8
  parameter int unsigned BEATS = BeatsDefault  // 1..16
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NCH-1:0]         rd_req,
  input  logic [NCH-1:0]         wr_req,
  output logic [NCH-1:0]         req_done,
  output logic [NCH-1:0]         req_err,
  output logic                   mst_start,
  output logic                   mst_write,
  output logic [$clog2(NCH)-1:0] mst_ch,
  input  logic                   mst_ready,
  input  logic                   mst_beat,
  input  logic                   mst_err,
  output logic                   busy
);

  localparam int unsigned ChW  = $clog2(NCH);
  localparam int unsigned CntW = $clog2(BEATS + 1);

  arb_state_e     state_q, state_d;
  logic [ChW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic           write_q, write_d;

  logic [NCH-1:0] req_any;
  logic [ChW-1:0] pick_ch;
  logic           pick_valid;

  assign req_any = rd_req | wr_req;

  rr_pick #(
    .NCH(NCH)
  ) u_rr_pick (
    .req  (req_any),
    .ptr  (rr_ptr_q),
    .grant(pick_ch),
    .valid(pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ch_d      = ch_q;
    write_d   = write_q;
    mst_start = 1'b0;
    req_done  = '0;
    req_err   = '0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          ch_d    = pick_ch;
          // Drain before refill: a pending write beats a pending read on the same channel.
          write_d = wr_req[pick_ch];
          state_d = StGrant;
        end
      end

      StGrant: begin
        mst_start = mst_ready;
        if (mst_ready) begin
          state_d = StXfer;
        end
      end

      StXfer: begin
        // Error takes priority even when it lands on the final beat.
        if (mst_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (mst_beat) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(BEATS)) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        req_done[ch_q] = 1'b1;
        req_err[ch_q]  = err_q;
        rr_ptr_d       = ChW'(wrap_idx(32'(ch_q) + 32'd1, NCH));
        cnt_d          = '0;
        err_d          = 1'b0;
        state_d        = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Reset abandons any transfer in flight; no req_done is produced for it.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ch_q     <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ch_q     <= ch_d;
      write_q  <= write_d;
    end
  end

  assign mst_ch    = ch_q;
  assign mst_write = write_q;
  assign busy      = (state_q != StIdle);

  a_done_onehot: assert property (@(posedge hclk) disable iff (!hresetn)
    $onehot0(req_done));

  a_start_in_grant: assert property (@(posedge hclk) disable iff (!hresetn)
    mst_start |-> (state_q == StGrant));

endmodule

// File: tb/tb_dma_req_arb.sv
module tb_dma_req_arb;

  localparam int unsigned NCH   = 4;
  localparam int unsigned BEATS = 8;

  logic           hclk = 1'b0;
  logic           hresetn;
  logic [NCH-1:0] rd_req, wr_req, req_done, req_err;
  logic           mst_start, mst_write, mst_ready, mst_beat, mst_err, busy;
  logic [1:0]     mst_ch;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  dma_req_arb #(
    .NCH  (NCH),
    .BEATS(BEATS)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .rd_req   (rd_req),
    .wr_req   (wr_req),
    .req_done (req_done),
    .req_err  (req_err),
    .mst_start(mst_start),
    .mst_write(mst_write),
    .mst_ch   (mst_ch),
    .mst_ready(mst_ready),
    .mst_beat (mst_beat),
    .mst_err  (mst_err),
    .busy     (busy)
  );

  typedef struct {
    logic [3:0] rd;
    logic [3:0] wr;
    int         rdy_dly;
    int         err_beat;  // 0 = no error, else beat number carrying mst_err
    int         exp_ch;
    bit         exp_w;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  // Spec-level model for the random phase: pending requests and round-robin pointer.
  bit wr_p[NCH];
  bit rd_p[NCH];
  int m_ptr;

  function automatic vec_t mk(input logic [3:0] rd, input logic [3:0] wr, input int rdy,
                              input int eb, input int ch, input bit w);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rdy_dly = rdy; v.err_beat = eb; v.exp_ch = ch; v.exp_w = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic noise_reqs(input bit noise);
    if (noise) begin
      rd_req = 4'($urandom);
      wr_req = 4'($urandom);
    end
  endtask

  task automatic chk_grant(input string tag, input int exp_ch, input bit exp_w);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ch"}, 32'(mst_ch), 32'(exp_ch));
    chk({tag, "_write"}, 32'(mst_write), 32'(exp_w));
  endtask

  // Runs one complete transfer starting in an IDLE cycle; ends at the start of the
  // following IDLE cycle.
  task automatic run_xfer(input logic [3:0] rd, input logic [3:0] wr, input int rdy_dly,
                          input int err_beat, input int gap_max, input bit noise,
                          input int exp_ch, input bit exp_w);
    logic [3:0] exp_done;
    int gap;
    exp_done = 4'(1 << exp_ch);

    rd_req    = rd;
    wr_req    = wr;
    mst_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mst_beat  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mst_err   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_start", 32'(mst_start), 32'd0);
    chk("idle_done", 32'(req_done), 32'd0);
    step();

    for (int i = 0; i < rdy_dly; i++) begin
      mst_ready = 1'b0;
      mst_beat  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mst_err   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      noise_reqs(noise);
      #1;
      chk("grant_wait_start", 32'(mst_start), 32'd0);
      chk_grant("grant_wait", exp_ch, exp_w);
      step();
    end
    mst_ready = 1'b1;
    mst_beat  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    mst_err   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    noise_reqs(noise);
    #1;
    chk("grant_start", 32'(mst_start), 32'd1);
    chk_grant("grant", exp_ch, exp_w);
    step();
    mst_ready = 1'b0;

    for (int k = 1; k <= BEATS; k++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gap; g++) begin
        mst_beat = 1'b0;
        mst_err  = 1'b0;
        noise_reqs(noise);
        #1;
        chk("xfer_gap_done", 32'(req_done), 32'd0);
        chk("xfer_gap_start", 32'(mst_start), 32'd0);
        chk_grant("xfer_gap", exp_ch, exp_w);
        step();
      end
      mst_beat = 1'b1;
      mst_err  = (k == err_beat);
      noise_reqs(noise);
      #1;
      chk("xfer_beat_done", 32'(req_done), 32'd0);
      chk_grant("xfer_beat", exp_ch, exp_w);
      step();
      if (k == err_beat) break;
    end

    mst_beat = 1'b0;
    mst_err  = 1'b0;
    noise_reqs(noise);
    #1;
    chk("done_pulse", 32'(req_done), 32'(exp_done));
    chk("done_err", 32'(req_err), (err_beat != 0) ? 32'(exp_done) : 32'd0);
    chk("done_start", 32'(mst_start), 32'd0);
    chk_grant("done", exp_ch, exp_w);
    step();
  endtask

  task automatic run_random(input int n);
    int c;
    int idx;
    int eb;
    logic [3:0] rv, wv;
    bit any;
    for (int t = 0; t < n; t++) begin
      any = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 4) == 0) wr_p[i] = 1'b1;
        if ($urandom_range(0, 4) == 0) rd_p[i] = 1'b1;
        any = any | wr_p[i] | rd_p[i];
      end
      if (!any) rd_p[$urandom_range(0, NCH - 1)] = 1'b1;

      c = -1;
      for (int i = 0; i < NCH; i++) begin
        idx = (m_ptr + i) % NCH;
        if (c < 0 && (wr_p[idx] || rd_p[idx])) c = idx;
      end
      for (int i = 0; i < NCH; i++) begin
        rv[i] = rd_p[i];
        wv[i] = wr_p[i];
      end
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, BEATS)) : 0;

      run_xfer(rv, wv, int'($urandom_range(0, 3)), eb, 2, 1'b1, c, wr_p[c]);

      if (wr_p[c]) wr_p[c] = 1'b0;
      else         rd_p[c] = 1'b0;
      m_ptr = (c + 1) % NCH;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Expected grants follow the round-robin pointer from reset (0) through the table.
    vecs[0]  = mk(4'b0000, 4'b0100, 0, 0, 2, 1'b1);  // lone ch2 write
    vecs[1]  = mk(4'b1000, 4'b0000, 0, 0, 3, 1'b0);
    vecs[2]  = mk(4'b1111, 4'b0000, 0, 0, 0, 1'b0);  // all reading: 0,1,2,3,0
    vecs[3]  = mk(4'b1111, 4'b0000, 0, 0, 1, 1'b0);
    vecs[4]  = mk(4'b1111, 4'b0000, 0, 0, 2, 1'b0);
    vecs[5]  = mk(4'b1111, 4'b0000, 0, 0, 3, 1'b0);
    vecs[6]  = mk(4'b1111, 4'b0000, 0, 0, 0, 1'b0);
    vecs[7]  = mk(4'b0010, 4'b0010, 0, 0, 1, 1'b1);  // both directions: write first
    vecs[8]  = mk(4'b0010, 4'b0000, 0, 0, 1, 1'b0);  // then the read
    vecs[9]  = mk(4'b0001, 4'b1000, 0, 0, 3, 1'b1);  // ptr 2 -> ch3 before ch0
    vecs[10] = mk(4'b0001, 4'b0000, 0, 3, 0, 1'b0);  // error on beat 3
    vecs[11] = mk(4'b0001, 4'b0000, 5, 0, 0, 1'b0);  // ready held low 5 cycles
    vecs[12] = mk(4'b0000, 4'b0110, 0, 0, 1, 1'b1);
    vecs[13] = mk(4'b0000, 4'b0001, 0, 8, 0, 1'b1);  // error on the final beat

    hresetn   = 1'b0;
    rd_req    = 4'b1111;
    wr_req    = 4'b1111;
    mst_ready = 1'b1;
    mst_beat  = 1'b1;
    mst_err   = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mst_start), 32'd0);
    chk("rst_ch", 32'(mst_ch), 32'd0);
    chk("rst_write", 32'(mst_write), 32'd0);
    chk("rst_done", 32'(req_done), 32'd0);
    chk("rst_err", 32'(req_err), 32'd0);
    rd_req    = '0;
    wr_req    = '0;
    mst_ready = 1'b0;
    mst_beat  = 1'b0;
    hresetn   = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_xfer(vecs[i].rd, vecs[i].wr, vecs[i].rdy_dly, vecs[i].err_beat, 0, 1'b0,
               vecs[i].exp_ch, vecs[i].exp_w);
    end

    // Reset in the middle of a ch3 read after 4 beats (pointer is 1 here).
    rd_req = 4'b1000;
    wr_req = 4'b0000;
    step();
    mst_ready = 1'b1;
    #1;
    chk("mid_start", 32'(mst_start), 32'd1);
    chk("mid_ch", 32'(mst_ch), 32'd3);
    step();
    mst_ready = 1'b0;
    mst_beat  = 1'b1;
    for (int k = 0; k < 4; k++) step();
    mst_beat = 1'b0;
    hresetn  = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ch", 32'(mst_ch), 32'd0);
    chk("mid_rst_start", 32'(mst_start), 32'd0);
    chk("mid_rst_write", 32'(mst_write), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_done", 32'(req_done), 32'd0);
      chk("mid_rst_err", 32'(req_err), 32'd0);
    end
    hresetn = 1'b1;
    rd_req  = '0;
    // Pointer must restart at 0: ch0 beats ch3.
    run_xfer(4'b1001, 4'b0000, 0, 0, 0, 1'b0, 0, 1'b0);
    run_xfer(4'b1000, 4'b0000, 0, 0, 0, 1'b0, 3, 1'b0);

    for (int i = 0; i < NCH; i++) begin
      wr_p[i] = 1'b0;
      rd_p[i] = 1'b0;
    end
    m_ptr = 0;
    run_random(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
